apb_master: RTL and testbench
=============================

Name: apb_master

Overview:
- APB3/APB4 requester that drives the timer's tim_* slave port from a simple command/response interface.
- Used by bus bridges and by the verification harness to issue timer register reads and writes.
- Handles one transaction at a time, including the SETUP and ACCESS phases, PREADY wait states, PSLVERR capture and a PREADY timeout.

Parameters:
- ADDR_W, 12, APB address width.
- DATA_W, 32, APB data width. PSTRB width is DATA_W/8.
- TIMEOUT, 16, maximum ACCESS-phase cycles to wait for PREADY. 0 disables the timeout.

Ports:
- sys_clk  in  1  clock.
- sys_rst  in  1  reset. One clock; reset is synchronous and active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  ADDR_W  target address.
- cmd_wdata  in  DATA_W  write data.
- cmd_strb  in  DATA_W/8  write byte strobes.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed when rsp_valid&&rsp_ready.
- rsp_rdata  out  DATA_W  read data. 0 for writes and for timeouts.
- rsp_err  out  1  PSLVERR seen, or timeout.
- rsp_timeout  out  1  transaction aborted by timeout.
- tim_psel  out  1  APB PSEL.
- tim_penable  out  1  APB PENABLE.
- tim_pwrite  out  1  APB PWRITE.
- tim_paddr  out  ADDR_W  APB PADDR.
- tim_pwdata  out  DATA_W  APB PWDATA.
- tim_pstrb  out  DATA_W/8  APB PSTRB.
- tim_prdata  in  DATA_W  APB PRDATA.
- tim_pready  in  1  APB PREADY.
- tim_pslverr  in  1  APB PSLVERR.

Behaviour:
- FSM states: IDLE, SETUP, ACCESS, RESP. All outputs are registered except cmd_ready.
- Reset (sys_rst=1 at a clock edge):
  - State goes to IDLE.
  - tim_psel, tim_penable, tim_pwrite, rsp_valid, rsp_err and rsp_timeout go to 0.
  - tim_paddr, tim_pwdata, tim_pstrb and rsp_rdata go to 0.
  - The timeout counter goes to 0.
  - Reset mid-transaction aborts immediately: no response is issued and PSEL drops on the following cycle.
- IDLE:
  - cmd_ready=1; in all other states cmd_ready=0.
  - On accept, the address, data, strobes and direction are latched and the next state is SETUP.
  - In the SETUP cycle: tim_psel=1, tim_penable=0, and tim_paddr, tim_pwrite, tim_pwdata and tim_pstrb show the latched values.
  - For reads, tim_pstrb=0 and tim_pwdata holds its previous value.
- SETUP: always lasts exactly one cycle, then ACCESS.
- ACCESS:
  - tim_psel=1, tim_penable=1. Address, data and control are held stable.
  - The timeout counter increments each cycle in which tim_pready=0.
  - If tim_pready=1, the transaction completes:
    - rsp_rdata = tim_prdata for reads, 0 for writes.
    - rsp_err = tim_pslverr, rsp_timeout = 0.
    - Next cycle: psel=0, penable=0, state=RESP, rsp_valid=1.
  - Timeout: if TIMEOUT!=0, tim_pready=0 and the counter equals TIMEOUT-1, the transaction aborts.
    - rsp_rdata=0, rsp_err=1, rsp_timeout=1.
    - psel and penable drop and the state goes to RESP.
  - If tim_pready=1 arrives in the same cycle the timeout would fire, the PREADY completion wins.
  - Counter width is clog2(TIMEOUT+1). The counter clears on entry to SETUP.
- RESP:
  - rsp_valid=1 and rsp_* are held stable until rsp_ready=1. Then rsp_valid=0 and the state goes to IDLE.
  - cmd_ready is not asserted in RESP. A new command is accepted the cycle after the response handshake.
- Throughput and latency:
  - Minimum is 4 cycles per transaction with zero wait states and rsp_ready tied high.
  - Accept at cycle T: SETUP at T+1, ACCESS at T+2, rsp_valid at T+3, cmd_ready again at T+4.
- Bus rules:
  - tim_penable=1 never occurs without tim_psel=1.
  - tim_psel is never asserted in IDLE or RESP.
  - PSEL always deasserts for at least one cycle between transactions.

Test Plan:
1. Write addr 0x004, data 0xA5A5_0001, strb 0xF, pready=1, pslverr=0, rsp_ready=1 -> psel rises T+1; penable T+2; rsp_valid T+3 with rsp_err=0, rsp_rdata=0; cmd_ready at T+4.
2. Read addr 0x010 with pready low for 3 ACCESS cycles, prdata=0x1234_5678 -> penable held 4 cycles with paddr stable; rsp_rdata=0x1234_5678, rsp_err=0; pstrb=0 throughout.
3. Read with pready=1 and pslverr=1 -> rsp_err=1, rsp_timeout=0, rsp_rdata=prdata.
4. TIMEOUT=16, pready held 0 -> exactly 16 ACCESS cycles, then psel=0 and rsp_valid=1 with rsp_err=1, rsp_timeout=1, rsp_rdata=0. Repeat with pready=1 on the 16th cycle -> normal completion, rsp_timeout=0.
5. rsp_ready held 0 for 5 cycles while cmd_valid=1 -> rsp_* stable, cmd_ready=0, psel=0; after the handshake the next command is accepted the following cycle.
6. Assert sys_rst during ACCESS -> next cycle all outputs are at reset values and no rsp_valid pulse occurs; a subsequent write completes normally.

Source files
------------

// File: rtl/apb_master_if.sv
// Command/response and APB signal bundle for apb_master.
// The master modport is the requester's view; slave is the bench or bridge side.
interface apb_master_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  localparam int STRB_W = DATA_W / 8;

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [STRB_W-1:0] cmd_strb;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;

  logic              tim_psel;
  logic              tim_penable;
  logic              tim_pwrite;
  logic [ADDR_W-1:0] tim_paddr;
  logic [DATA_W-1:0] tim_pwdata;
  logic [STRB_W-1:0] tim_pstrb;
  logic [DATA_W-1:0] tim_prdata;
  logic              tim_pready;
  logic              tim_pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, rsp_ready,
           tim_prdata, tim_pready, tim_pslverr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           tim_psel, tim_penable, tim_pwrite, tim_paddr, tim_pwdata, tim_pstrb
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, rsp_ready,
           tim_prdata, tim_pready, tim_pslverr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           tim_psel, tim_penable, tim_pwrite, tim_paddr, tim_pwdata, tim_pstrb
  );
endinterface

// File: rtl/apb_master.sv
// Single-outstanding APB requester: turns one command into a SETUP/ACCESS
// sequence and returns the result, with PSLVERR capture and a PREADY timeout.
module apb_master #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input logic         sys_clk,
  input logic         sys_rst,
  apb_master_if.master bus
);
  // state  | meaning
  // IDLE   | cmd_ready high, waiting for a command
  // SETUP  | PSEL high, PENABLE low, one cycle
  // ACCESS | PSEL+PENABLE high, waiting for PREADY or timeout
  // RESP   | rsp_valid high until rsp_ready
  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t            state, state_nxt;
  logic              psel, psel_nxt, penable, penable_nxt, pwrite, pwrite_nxt;
  logic [ADDR_W-1:0] paddr, paddr_nxt;
  logic [DATA_W-1:0] pwdata, pwdata_nxt, rdata, rdata_nxt;
  logic [STRB_W-1:0] pstrb, pstrb_nxt;
  logic              rvalid, rvalid_nxt, rerr, rerr_nxt, rto, rto_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state   <= IDLE;
      psel    <= 1'b0;
      penable <= 1'b0;
      pwrite  <= 1'b0;
      paddr   <= '0;
      pwdata  <= '0;
      pstrb   <= '0;
      rvalid  <= 1'b0;
      rerr    <= 1'b0;
      rto     <= 1'b0;
      rdata   <= '0;
      cnt     <= '0;
    end else begin
      state   <= state_nxt;
      psel    <= psel_nxt;
      penable <= penable_nxt;
      pwrite  <= pwrite_nxt;
      paddr   <= paddr_nxt;
      pwdata  <= pwdata_nxt;
      pstrb   <= pstrb_nxt;
      rvalid  <= rvalid_nxt;
      rerr    <= rerr_nxt;
      rto     <= rto_nxt;
      rdata   <= rdata_nxt;
      cnt     <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    psel_nxt    = psel;
    penable_nxt = penable;
    pwrite_nxt  = pwrite;
    paddr_nxt   = paddr;
    pwdata_nxt  = pwdata;
    pstrb_nxt   = pstrb;
    rvalid_nxt  = rvalid;
    rerr_nxt    = rerr;
    rto_nxt     = rto;
    rdata_nxt   = rdata;
    cnt_nxt     = cnt;
    case (state)
      IDLE: begin
        if (bus.cmd_valid) begin
          state_nxt   = SETUP;
          psel_nxt    = 1'b1;
          penable_nxt = 1'b0;
          pwrite_nxt  = bus.cmd_write;
          paddr_nxt   = bus.cmd_addr;
          cnt_nxt     = '0;
          // Reads leave PWDATA untouched and drive no strobes.
          if (bus.cmd_write) begin
            pwdata_nxt = bus.cmd_wdata;
            pstrb_nxt  = bus.cmd_strb;
          end else begin
            pstrb_nxt  = '0;
          end
        end
      end
      SETUP: begin
        state_nxt   = ACCESS;
        penable_nxt = 1'b1;
      end
      ACCESS: begin
        if (bus.tim_pready) begin
          state_nxt   = RESP;
          psel_nxt    = 1'b0;
          penable_nxt = 1'b0;
          rvalid_nxt  = 1'b1;
          rdata_nxt   = pwrite ? '0 : bus.tim_prdata;
          rerr_nxt    = bus.tim_pslverr;
          rto_nxt     = 1'b0;
        end else if (TIMEOUT != 0 && cnt == CNT_LAST) begin
          state_nxt   = RESP;
          psel_nxt    = 1'b0;
          penable_nxt = 1'b0;
          rvalid_nxt  = 1'b1;
          rdata_nxt   = '0;
          rerr_nxt    = 1'b1;
          rto_nxt     = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_nxt  = IDLE;
          rvalid_nxt = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.cmd_ready   = (state == IDLE);
  assign bus.rsp_valid   = rvalid;
  assign bus.rsp_rdata   = rdata;
  assign bus.rsp_err     = rerr;
  assign bus.rsp_timeout = rto;
  assign bus.tim_psel    = psel;
  assign bus.tim_penable = penable;
  assign bus.tim_pwrite  = pwrite;
  assign bus.tim_paddr   = paddr;
  assign bus.tim_pwdata  = pwdata;
  assign bus.tim_pstrb   = pstrb;
endmodule

// File: tb/tb_apb_master.sv
// Directed and randomized transactions against apb_master, checked cycle by
// cycle against a phase-level model of the expected bus and response behaviour.
module tb_apb_master;
  localparam int ADDR_W  = 12;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  int   tests   = 0;
  int   failed  = 0;
  logic [DATA_W-1:0] last_wdata = '0;

  apb_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  apb_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // wt = number of ACCESS cycles with PREADY low before it rises.
  task automatic run_txn(input bit wr, input logic [11:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input int wt, input bit slverr,
                         input logic [31:0] prdata, input int rdly, input bit hold_cmd);
    int          n_acc;
    bit          e_to, e_err;
    logic [31:0] e_rdata;
    logic [3:0]  e_pstrb;
    e_to    = (TIMEOUT != 0) && (wt >= TIMEOUT);
    n_acc   = e_to ? TIMEOUT : wt + 1;
    e_err   = e_to ? 1'b1 : slverr;
    e_rdata = (e_to || wr) ? 32'h0 : prdata;
    e_pstrb = wr ? strb : 4'h0;
    if (wr) last_wdata = wdata;

    check("idle_cmd_ready", bus.cmd_ready, 1);
    check("idle_psel", bus.tim_psel, 0);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
    bus.cmd_strb  = strb;
    tick();
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'($urandom);
    bus.cmd_addr  = 12'($urandom);
    bus.cmd_wdata = $urandom;
    bus.cmd_strb  = 4'($urandom);

    check("setup_psel", bus.tim_psel, 1);
    check("setup_penable", bus.tim_penable, 0);
    check("setup_paddr", bus.tim_paddr, addr);
    check("setup_pwrite", bus.tim_pwrite, wr);
    check("setup_pwdata", bus.tim_pwdata, last_wdata);
    check("setup_pstrb", bus.tim_pstrb, e_pstrb);
    check("setup_cmd_ready", bus.cmd_ready, 0);
    tick();

    for (int k = 0; k < n_acc; k++) begin
      check("acc_psel", bus.tim_psel, 1);
      check("acc_penable", bus.tim_penable, 1);
      check("acc_paddr", bus.tim_paddr, addr);
      check("acc_pwrite", bus.tim_pwrite, wr);
      check("acc_pwdata", bus.tim_pwdata, last_wdata);
      check("acc_pstrb", bus.tim_pstrb, e_pstrb);
      check("acc_rsp_valid", bus.rsp_valid, 0);
      check("acc_cmd_ready", bus.cmd_ready, 0);
      bus.tim_pready  = (k == wt);
      bus.tim_pslverr = (k == wt) ? slverr : 1'($urandom);
      bus.tim_prdata  = (k == wt) ? prdata : $urandom;
      tick();
    end
    bus.tim_pready = 1'b0;
    bus.cmd_valid  = hold_cmd;

    for (int d = 0; d <= rdly; d++) begin
      check("rsp_valid", bus.rsp_valid, 1);
      check("rsp_rdata", bus.rsp_rdata, e_rdata);
      check("rsp_err", bus.rsp_err, e_err);
      check("rsp_timeout", bus.rsp_timeout, e_to);
      check("rsp_psel", bus.tim_psel, 0);
      check("rsp_penable", bus.tim_penable, 0);
      check("rsp_cmd_ready", bus.cmd_ready, 0);
      bus.rsp_ready = (d == rdly);
      tick();
    end
    bus.rsp_ready = 1'b0;
    check("post_rsp_valid", bus.rsp_valid, 0);
    check("post_cmd_ready", bus.cmd_ready, 1);
    check("post_psel", bus.tim_psel, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_psel"}, bus.tim_psel, 0);
    check({tag, "_penable"}, bus.tim_penable, 0);
    check({tag, "_pwrite"}, bus.tim_pwrite, 0);
    check({tag, "_paddr"}, bus.tim_paddr, 0);
    check({tag, "_pwdata"}, bus.tim_pwdata, 0);
    check({tag, "_pstrb"}, bus.tim_pstrb, 0);
    check({tag, "_rsp_valid"}, bus.rsp_valid, 0);
    check({tag, "_rsp_err"}, bus.rsp_err, 0);
    check({tag, "_rsp_timeout"}, bus.rsp_timeout, 0);
    check({tag, "_rsp_rdata"}, bus.rsp_rdata, 0);
    check({tag, "_cmd_ready"}, bus.cmd_ready, 1);
  endtask

  initial begin
    bus.cmd_valid   = 1'b0;
    bus.cmd_write   = 1'b0;
    bus.cmd_addr    = '0;
    bus.cmd_wdata   = '0;
    bus.cmd_strb    = '0;
    bus.rsp_ready   = 1'b0;
    bus.tim_prdata  = '0;
    bus.tim_pready  = 1'b0;
    bus.tim_pslverr = 1'b0;

    tick();
    check_reset_outputs("reset");
    tick();
    sys_rst = 1'b0;
    tick();

    // Zero-wait write, minimum latency
    run_txn(1'b1, 12'h004, 32'hA5A5_0001, 4'hF, 0, 1'b0, 32'h0, 0, 1'b0);
    // Read with three wait states
    run_txn(1'b0, 12'h010, 32'hDEAD_BEEF, 4'hF, 3, 1'b0, 32'h1234_5678, 0, 1'b0);
    // Read with slave error
    run_txn(1'b0, 12'h020, 32'h0, 4'h0, 0, 1'b1, 32'hCAFE_0003, 0, 1'b0);
    // Timeout, then PREADY on the last allowed cycle
    run_txn(1'b0, 12'h030, 32'h0, 4'h0, 16, 1'b0, 32'h5555_AAAA, 0, 1'b0);
    run_txn(1'b1, 12'h034, 32'h0BAD_F00D, 4'h3, 15, 1'b0, 32'h0, 0, 1'b0);
    // Stalled response with a new command already pending
    run_txn(1'b1, 12'h040, 32'h1111_2222, 4'h5, 1, 1'b0, 32'h0, 5, 1'b1);
    run_txn(1'b0, 12'h044, 32'h0, 4'hF, 0, 1'b0, 32'h7777_8888, 0, 1'b0);

    // Reset in the middle of ACCESS
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 12'h050;
    bus.cmd_wdata = 32'h9999_0000;
    bus.cmd_strb  = 4'hF;
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    tick();
    check("pre_rst_penable", bus.tim_penable, 1);
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    last_wdata = '0;
    check_reset_outputs("midrst");
    for (int i = 0; i < 3; i++) begin
      check("midrst_no_rsp", bus.rsp_valid, 0);
      check("midrst_no_psel", bus.tim_psel, 0);
      tick();
    end
    run_txn(1'b1, 12'h054, 32'h0F0F_F0F0, 4'hC, 0, 1'b0, 32'h0, 0, 1'b0);

    // Randomized traffic, including some timeouts
    for (int n = 0; n < 25; n++) begin
      int wt;
      wt = ($urandom_range(0, 5) == 0) ? int'($urandom_range(14, 18)) : int'($urandom_range(0, 4));
      run_txn(1'($urandom), 12'($urandom), $urandom, 4'($urandom), wt, 1'($urandom),
              $urandom, int'($urandom_range(0, 3)), 1'($urandom));
    end
    bus.cmd_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
